tim_irq_coalesce: RTL and testbench

- Interrupt post-processing stage directly downstream of the APB4 timer.
- Consumes the timer's level overflow interrupt and converts its rising edges into counted events.
- Raises a single coalesced CPU interrupt once either an event-count threshold or a cycle timeout is reached.
- Holds that interrupt until software acknowledges it, and reports the event count and overflow status.

---
 rtl/tim_irq_coalesce.sv | 162 ++++++++++++++++
 tb/tb_tim_irq_coalesce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_irq_coalesce.sv
// Interrupt coalescer behind the APB4 timer: counts rising edges of the timer's level IRQ
// and raises one held CPU interrupt on an event-count threshold or a cycle timeout.
`timescale 1ns/1ps

module tim_irq_coalesce #(
    parameter int CNT_WIDTH = 8,
    parameter int TMO_WIDTH = 16,
    parameter bit SYNC_EN   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 irq_src_i,
    input  logic [CNT_WIDTH-1:0] thresh_i,
    input  logic [TMO_WIDTH-1:0] tmo_i,
    input  logic                 mask_i,
    input  logic                 clr_i,
    output logic                 irq_o,
    output logic [CNT_WIDTH-1:0] evt_cnt_o,
    output logic                 ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

    logic src_s;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;
            logic [1:0] sync_d;

            always_comb begin
                sync_d = {sync_q[0], irq_src_i};
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign src_s = sync_q[1];
        end else begin : g_nosync
            assign src_s = irq_src_i;
        end
    endgenerate

    state_t                 state_q, state_d;
    logic                   prev_q, prev_d;
    logic [CNT_WIDTH-1:0]   evt_cnt_q, evt_cnt_d;
    logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   evt;
    logic                   th_is_one;
    logic [CNT_WIDTH-1:0]   th;
    logic [CNT_WIDTH:0]     cnt_sum;
    logic                   cnt_hit;
    logic                   tmo_hit;
    state_t                 batch_state;

    // prev follows the source even while disabled, so a level already high at enable is not an edge
    always_comb begin
        prev_d    = src_s;
        evt       = src_s & ~prev_q & en_i;
        th        = (thresh_i == '0) ? CNT_ONE : thresh_i;
        th_is_one = (th == CNT_ONE);
        cnt_sum   = {1'b0, evt_cnt_q} + {{CNT_WIDTH{1'b0}}, evt};
        cnt_hit   = (cnt_sum >= {1'b0, th});
        tmo_hit   = (tmo_i != '0) && (tmo_cnt_q == (tmo_i - TMO_ONE));
        batch_state = th_is_one ? FIRE : ACCUM;
    end

    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        ovf_d     = ovf_q;

        if (!en_i) begin
            state_d   = IDLE;
            evt_cnt_d = '0;
            tmo_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    evt_cnt_d = '0;
                    tmo_cnt_d = '0;
                    if (evt) begin
                        evt_cnt_d = CNT_ONE;
                        state_d   = batch_state;
                    end
                end
                ACCUM: begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    evt_cnt_d = cnt_sum[CNT_WIDTH] ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
                    if (cnt_hit || tmo_hit) begin
                        state_d = FIRE;
                    end
                end
                FIRE: begin
                    // An event landing on the acknowledge opens the next batch instead of being dropped
                    if (clr_i) begin
                        ovf_d     = 1'b0;
                        tmo_cnt_d = '0;
                        if (evt) begin
                            evt_cnt_d = CNT_ONE;
                            state_d   = batch_state;
                        end else begin
                            evt_cnt_d = '0;
                            state_d   = IDLE;
                        end
                    end else if (evt) begin
                        if (evt_cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            evt_cnt_d = evt_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    evt_cnt_d = '0;
                    tmo_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prev_q    <= 1'b0;
            evt_cnt_q <= '0;
            tmo_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            evt_cnt_q <= evt_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign irq_o     = (state_q == FIRE) & ~mask_i;
    assign evt_cnt_o = evt_cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_tim_irq_coalesce.sv
// Directed self-checking bench for tim_irq_coalesce (CNT_WIDTH=8, TMO_WIDTH=16, SYNC_EN=1).
`timescale 1ns/1ps

module tb_tim_irq_coalesce;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        irq_src_i;
    logic [7:0]  thresh_i;
    logic [15:0] tmo_i;
    logic        mask_i;
    logic        clr_i;
    logic        irq_o;
    logic [7:0]  evt_cnt_o;
    logic        ovf_o;

    int checks   = 0;
    int failures = 0;

    tim_irq_coalesce #(
        .CNT_WIDTH (8),
        .TMO_WIDTH (16),
        .SYNC_EN   (1'b1)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .irq_src_i (irq_src_i),
        .thresh_i  (thresh_i),
        .tmo_i     (tmo_i),
        .mask_i    (mask_i),
        .clr_i     (clr_i),
        .irq_o     (irq_o),
        .evt_cnt_o (evt_cnt_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clean source pulse: high for 'width' cycles, then low for 'gap' cycles
    task automatic applyStimulus(input int width, input int gap);
        irq_src_i = 1'b1;
        tick(width);
        irq_src_i = 1'b0;
        tick(gap);
    endtask

    initial begin
        rst_i     = 1'b1;
        en_i      = 1'b1;
        irq_src_i = 1'b0;
        thresh_i  = 8'd1;
        tmo_i     = 16'd0;
        mask_i    = 1'b0;
        clr_i     = 1'b0;

        tick(2);
        checkOutput("reset_irq", irq_o, 0);
        checkOutput("reset_cnt", evt_cnt_o, 0);
        checkOutput("reset_ovf", ovf_o, 0);
        rst_i = 1'b0;
        tick(2);

        $display("[TB] th=1 latency and acknowledge");
        irq_src_i = 1'b1;
        tick(2);
        checkOutput("lat_edge2_irq", irq_o, 0);
        tick(1);
        checkOutput("lat_edge3_irq", irq_o, 1);
        checkOutput("lat_edge3_cnt", evt_cnt_o, 1);
        tick(2);
        irq_src_i = 1'b0;
        tick(3);
        checkOutput("hold_irq", irq_o, 1);
        checkOutput("hold_cnt", evt_cnt_o, 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        checkOutput("clr_irq", irq_o, 0);
        checkOutput("clr_cnt", evt_cnt_o, 0);

        $display("[TB] threshold 4, count only");
        thresh_i = 8'd4;
        irq_src_i = 1'b1;
        tick(3);
        checkOutput("th4_cnt1", evt_cnt_o, 1);
        checkOutput("th4_irq1", irq_o, 0);
        irq_src_i = 1'b0;
        tick(3);
        irq_src_i = 1'b1;
        tick(3);
        checkOutput("th4_cnt2", evt_cnt_o, 2);
        tick(17);
        checkOutput("th4_level_cnt", evt_cnt_o, 2);
        irq_src_i = 1'b0;
        tick(3);
        applyStimulus(3, 0);
        checkOutput("th4_cnt3", evt_cnt_o, 3);
        checkOutput("th4_irq3", irq_o, 0);
        tick(3);
        irq_src_i = 1'b1;
        tick(3);
        checkOutput("th4_fire_irq", irq_o, 1);
        checkOutput("th4_fire_cnt", evt_cnt_o, 4);
        irq_src_i = 1'b0;
        tick(3);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        checkOutput("th4_clr_cnt", evt_cnt_o, 0);

        $display("[TB] timeout 50");
        thresh_i = 8'd10;
        tmo_i    = 16'd50;
        applyStimulus(3, 3);
        applyStimulus(3, 0);
        checkOutput("tmo_cnt2", evt_cnt_o, 2);
        tick(43);
        checkOutput("tmo_edge49_irq", irq_o, 0);
        tick(1);
        checkOutput("tmo_edge50_irq", irq_o, 1);
        checkOutput("tmo_edge50_cnt", evt_cnt_o, 2);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        tmo_i = 16'd0;
        applyStimulus(3, 3);
        tick(1000);
        checkOutput("notmo_irq", irq_o, 0);
        checkOutput("notmo_cnt", evt_cnt_o, 1);
        en_i = 1'b0;
        tick(1);
        en_i = 1'b1;
        checkOutput("en_low_accum_cnt", evt_cnt_o, 0);

        $display("[TB] saturation and overflow");
        thresh_i = 8'd1;
        applyStimulus(3, 3);
        checkOutput("sat_fire_cnt", evt_cnt_o, 1);
        for (int i = 0; i < 254; i++) applyStimulus(1, 1);
        tick(3);
        checkOutput("sat_255_cnt", evt_cnt_o, 255);
        checkOutput("sat_255_ovf", ovf_o, 0);
        for (int i = 0; i < 46; i++) applyStimulus(1, 1);
        tick(3);
        checkOutput("sat_over_cnt", evt_cnt_o, 255);
        checkOutput("sat_over_ovf", ovf_o, 1);
        checkOutput("sat_over_irq", irq_o, 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        checkOutput("sat_clr_cnt", evt_cnt_o, 0);
        checkOutput("sat_clr_ovf", ovf_o, 0);
        checkOutput("sat_clr_irq", irq_o, 0);

        $display("[TB] acknowledge coincident with event");
        applyStimulus(3, 3);
        thresh_i  = 8'd3;
        irq_src_i = 1'b1;
        tick(2);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        irq_src_i = 1'b0;
        checkOutput("coinc_cnt", evt_cnt_o, 1);
        checkOutput("coinc_irq", irq_o, 0);
        thresh_i = 8'd1;
        tick(1);
        checkOutput("thchg_irq", irq_o, 1);
        checkOutput("thchg_cnt", evt_cnt_o, 1);
        tick(3);

        $display("[TB] mask and enable");
        mask_i = 1'b1;
        #1;
        checkOutput("mask_irq", irq_o, 0);
        tick(3);
        checkOutput("mask_hold_irq", irq_o, 0);
        checkOutput("mask_hold_cnt", evt_cnt_o, 1);
        mask_i = 1'b0;
        #1;
        checkOutput("unmask_irq", irq_o, 1);
        en_i = 1'b0;
        tick(1);
        checkOutput("en_low_irq", irq_o, 0);
        checkOutput("en_low_cnt", evt_cnt_o, 0);
        irq_src_i = 1'b1;
        tick(4);
        en_i = 1'b1;
        tick(3);
        checkOutput("en_rise_cnt", evt_cnt_o, 0);
        checkOutput("en_rise_irq", irq_o, 0);
        irq_src_i = 1'b0;
        tick(3);

        $display("[TB] asynchronous reset");
        thresh_i = 8'd4;
        applyStimulus(3, 3);
        applyStimulus(3, 3);
        checkOutput("rst_pre_cnt", evt_cnt_o, 2);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("rst_accum_cnt", evt_cnt_o, 0);
        checkOutput("rst_accum_irq", irq_o, 0);
        checkOutput("rst_accum_ovf", ovf_o, 0);
        tick(1);
        rst_i = 1'b0;
        tick(2);
        thresh_i  = 8'd1;
        irq_src_i = 1'b1;
        tick(3);
        checkOutput("rst_pre_fire_irq", irq_o, 1);
        irq_src_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("rst_fire_irq", irq_o, 0);
        checkOutput("rst_fire_cnt", evt_cnt_o, 0);
        tick(1);
        rst_i = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
